// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding and the default operand width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full adder cell used by the serial add/subtract controller.
module FA (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic ca
);

    assign s  = a ^ b ^ c;
    assign ca = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one FA cell processes a WIDTH-bit
// operand pair LSB first, one bit per clock, with a start/busy/done handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    // Step after which the carry flop holds the carry into the MSB.
    localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             msb_cin;
    logic             fa_s;
    logic             fa_ca;
    logic             load;
    logic             last_step;

    FA u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .c  (carry),
        .s  (fa_s),
        .ca (fa_ca)
    );

    // New operands are accepted only when not running.
    assign load      = start && (state != RUN);
    assign last_step = (state == RUN) && (cnt == CNT_LAST);
    // Result shifts in from the MSB; after WIDTH steps bit 0 is the LSB.
    assign res_nxt   = {fa_s, (WIDTH-1)'(res_sr >> 1)};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand load, bit-serial datapath and result capture on the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            msb_cin <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (load) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            res_sr <= res_nxt;
            carry  <= fa_ca;
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            if (!last_step) begin
                cnt <= cnt + CW'(1);
            end
            if (cnt == CNT_PEN) begin
                msb_cin <= fa_ca;
            end
            // Outputs are written as the FSM enters DONE so they are
            // valid for the whole done cycle and held afterwards.
            if (last_step) begin
                sum  <= res_nxt;
                cout <= fa_ca;
                ovf  <= msb_cin ^ fa_ca;
            end
        end
    end

endmodule
